uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_tx_fifo_if.sv | 25 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types for the buffered UART transmitter.
//   parityMode_t : parity selection for a frame (none / even / odd)
//   txState_t    : transmitter state machine encoding, also exported for debug
//   parityBit()  : parity bit for a data word, zero-extended to 8 bits
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parityMode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } txState_t;

    // Baud counter width covers CLKS_PER_BIT up to 65535.
    localparam int BAUD_W = 16;
    // Bit counter covers up to 8 data bits or 2 stop bits.
    localparam int BIT_W  = 3;

    // Unused upper bits of the word must be zero so they do not disturb the XOR.
    function automatic logic parityBit(parityMode_t mode, logic [7:0] word);
        logic p;
        p = 1'b0;
        case (mode)
            PAR_EVEN: p = ^word;
            PAR_ODD:  p = ~^word;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the buffered UART transmitter.
//   Din      : word to enqueue (master -> slave)
//   Wr       : write strobe (master -> slave)
//   Ready    : FIFO not full (slave -> master)
//   Level    : FIFO occupancy, 0..DEPTH (slave -> master)
//   Overflow : one-cycle pulse after a dropped write (slave -> master)
//
// Handshake: a word is taken on a rising edge where Wr=1 and Ready=1, or where
// Wr=1 and the transmitter pops the head on that same edge (the freed slot is
// reused). A write with Ready=0 and no pop is dropped and reported on Overflow
// in the following cycle. Wr may be held high across edges to write a burst;
// Din is sampled only on accepting edges and may change freely afterwards.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
);
    logic [DATA_BITS-1:0]    Din;
    logic                    Wr;
    logic                    Ready;
    logic [$clog2(DEPTH):0]  Level;
    logic                    Overflow;

    modport master (output Din, Wr, input Ready, Level, Overflow);
    modport slave  (input Din, Wr, output Ready, Level, Overflow);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count.
//   clk, Reset_n : clock, asynchronous active-low reset (clears pointers/Level)
//   wrEn, wrData : write request and data
//   rdEn         : pop request; rdData always shows the current head
//   Level        : occupancy 0..DEPTH (one bit wider than the pointers)
//   full, empty  : decoded from Level
// A write on a full FIFO is still taken when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    Reset_n,
    input  logic                    wrEn,
    input  logic [WIDTH-1:0]        wrData,
    input  logic                    rdEn,
    output logic [WIDTH-1:0]        rdData,
    output logic [$clog2(DEPTH):0]  Level,
    output logic                    full,
    output logic                    empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doWrite;
    logic             doRead;

    assign full    = (Level == LVL_W'(DEPTH));
    assign empty   = (Level == '0);
    assign doRead  = rdEn && !empty;
    assign doWrite = wrEn && (!full || doRead);
    assign rdData  = mem[rdPtr];

    // Storage carries no reset; pointers and Level decide what is valid.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Level <= '0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doRead) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doWrite, doRead})
                2'b10:   Level <= Level + LVL_W'(1);
                2'b01:   Level <= Level - LVL_W'(1);
                default: Level <= Level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO of words feeding a serial framer.
//   clk      : sole clock, rising edge
//   Reset_n  : asynchronous active-low reset; aborts any frame, drops FIFO data
//   bus      : write side (Din, Wr, Ready, Level, Overflow)
//   Sent     : one-cycle pulse during the last cycle of the final stop bit
//   Busy     : high whenever the state is not IDLE
//   Sout     : serial line, idle high, driven from a flop
//   State    : current state, for debug
// Frame, LSB first: start(0), DATA_BITS data, optional parity, STOP_BITS stop(1).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 5208,
    parameter int          DATA_BITS    = 8,
    parameter parityMode_t PARITY       = PAR_ODD,
    parameter int          STOP_BITS    = 1,
    parameter int          DEPTH        = 16
) (
    input  logic             clk,
    input  logic             Reset_n,
    uart_tx_fifo_if.slave    bus,
    output logic             Sent,
    output logic             Busy,
    output logic             Sout,
    output txState_t         State
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    txState_t               state;
    txState_t               stateNext;
    logic [BAUD_W-1:0]      baudCnt;
    logic [BIT_W-1:0]       bitCnt;
    logic [DATA_BITS-1:0]   shiftReg;
    logic                   parReg;
    logic                   overflowReg;

    logic [DATA_BITS-1:0]   fifoHead;
    logic [LVL_W-1:0]       fifoLevel;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   pop;

    logic                   bitDone;
    logic                   lastData;
    logic                   lastStop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .Reset_n (Reset_n),
        .wrEn    (bus.Wr),
        .wrData  (bus.Din),
        .rdEn    (pop),
        .rdData  (fifoHead),
        .Level   (fifoLevel),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    assign bus.Level    = fifoLevel;
    assign bus.Ready    = !fifoFull;
    assign bus.Overflow = overflowReg;

    assign bitDone  = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign lastData = (bitCnt == BIT_W'(DATA_BITS - 1));
    assign lastStop = (bitCnt == BIT_W'(STOP_BITS - 1));

    assign Busy  = (state != IDLE);
    assign State = state;

    // Next state, pop and Sent. Leaving STOP with data waiting goes straight
    // to START so consecutive frames have no idle cycle between them.
    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        Sent      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    stateNext = START;
                    pop       = 1'b1;
                end
            end
            START: begin
                if (bitDone) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (bitDone && lastData) begin
                    stateNext = (PARITY == PAR_NONE) ? STOP : PAR;
                end
            end
            PAR: begin
                if (bitDone) begin
                    stateNext = STOP;
                end
            end
            STOP: begin
                if (bitDone && lastStop) begin
                    Sent = 1'b1;
                    if (!fifoEmpty) begin
                        stateNext = START;
                        pop       = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Baud counter restarts on every state entry and at each bit boundary;
    // bit counter restarts on every state entry.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            baudCnt <= '0;
            bitCnt  <= '0;
        end else begin
            if (stateNext != state || bitDone || state == IDLE) begin
                baudCnt <= '0;
            end else begin
                baudCnt <= baudCnt + BAUD_W'(1);
            end
            if (stateNext != state) begin
                bitCnt <= '0;
            end else if (bitDone) begin
                bitCnt <= bitCnt + BIT_W'(1);
            end
        end
    end

    // Parity is captured with the word so the shifting copy can be consumed.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shiftReg <= '0;
            parReg   <= 1'b0;
        end else if (pop) begin
            shiftReg <= fifoHead;
            parReg   <= parityBit(PARITY, 8'(fifoHead));
        end else if (state == DATA && bitDone) begin
            shiftReg <= shiftReg >> 1;
        end
    end

    // Sout changes on the edge that enters a state; inside DATA it moves to
    // the next bit (shiftReg[1], which becomes bit 0 on the same edge).
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Sout <= 1'b1;
        end else if (stateNext != state) begin
            case (stateNext)
                START:   Sout <= 1'b0;
                DATA:    Sout <= shiftReg[0];
                PAR:     Sout <= parReg;
                default: Sout <= 1'b1;
            endcase
        end else if (state == DATA && bitDone) begin
            Sout <= shiftReg[1];
        end
    end

    // A write is lost only when full and no pop frees a slot on that edge.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            overflowReg <= 1'b0;
        end else begin
            overflowReg <= bus.Wr && fifoFull && !pop;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: four instances with different frame formats,
// directed scenarios plus randomized bursts, a scoreboard queue of expected
// words and one line monitor per instance that rebuilds the expected frame.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int NI  = 4;
    localparam int CPB = 4;
    localparam int DEP = 4;
    localparam int DBITS [NI] = '{8, 8, 8, 5};
    localparam int SBITS [NI] = '{1, 1, 1, 2};
    localparam parityMode_t PMODE [NI] = '{PAR_ODD, PAR_EVEN, PAR_NONE, PAR_ODD};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic [7:0]    din [NI];
    logic [NI-1:0] wr;
    wire  [NI-1:0] sout, sent, busy, ready, ovf;
    wire  [2:0]    level [NI];
    wire  [2:0]    stDbg [NI];

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];
    int total = 0;
    int bad = 0;
    bit inFrame [NI];
    int frames [NI];
    int sentCnt [NI];

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void pushExp(int idx, logic [7:0] w);
        exp_q.push_back({2'(idx), w});
    endfunction

    function automatic int pending(int idx);
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][9:8] == 2'(idx)) n++;
        return n;
    endfunction

    function automatic logic [7:0] popExp(int idx, output bit found);
        logic [7:0] w = '0;
        found = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][9:8] == 2'(idx)) begin
                w = exp_q[i][7:0];
                exp_q.delete(i);
                found = 1'b1;
                break;
            end
        end
        return w;
    endfunction

    function automatic void dropExp(int idx);
        logic [9:0] keep[$];
        foreach (exp_q[i]) if (exp_q[i][9:8] != 2'(idx)) keep.push_back(exp_q[i]);
        exp_q = keep;
    endfunction

    // Reference frame: line level for each bit slot, LSB first; returns slot count.
    function automatic int buildFrame(int idx, logic [7:0] w, output logic [11:0] bits);
        int n = 0;
        int ones = 0;
        bits = '1;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < DBITS[idx]; i++) begin
            bits[n] = w[i]; n++;
            ones += int'(w[i]);
        end
        if (PMODE[idx] == PAR_EVEN) begin
            bits[n] = (ones % 2 == 1); n++;
        end else if (PMODE[idx] == PAR_ODD) begin
            bits[n] = (ones % 2 == 0); n++;
        end
        for (int s = 0; s < SBITS[idx]; s++) begin
            bits[n] = 1'b1; n++;
        end
        return n;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) if (sent[i]) sentCnt[i] <= sentCnt[i] + 1;
    end

    // Monitor: waits for a start bit, pops the expected word and checks every
    // cycle of the frame, the Sent pulse position and Busy.
    task automatic monitor(int idx);
        logic [11:0] bits;
        logic [11:0] obs;
        logic [7:0]  w;
        bit found, aborted, idleSentOk;
        int nb, wrongCycles, sentAt, sentHits, notBusy, i, c;
        forever begin
            idleSentOk = 1'b1;
            @(negedge clk);
            while (!(Reset_n && sout[idx] == 1'b0)) begin
                if (Reset_n && sent[idx]) idleSentOk = 1'b0;
                @(negedge clk);
            end
            inFrame[idx] = 1'b1;
            w = popExp(idx, found);
            check($sformatf("u%0d_frame_expected", idx), int'(found), 1);
            check($sformatf("u%0d_sent_idle_quiet", idx), int'(idleSentOk), 1);
            nb = buildFrame(idx, w, bits);
            obs = '1; wrongCycles = 0; sentAt = -1; sentHits = 0; notBusy = 0; aborted = 1'b0;
            for (int k = 0; k < nb * CPB; k++) begin
                if (k > 0) @(negedge clk);
                if (!Reset_n) begin
                    aborted = 1'b1;
                    break;
                end
                i = k / CPB;
                c = k % CPB;
                if (c == CPB / 2) obs[i] = sout[idx];
                if (sout[idx] !== bits[i]) wrongCycles++;
                if (sent[idx]) begin
                    sentHits++;
                    if (sentAt < 0) sentAt = k;
                end
                if (!busy[idx]) notBusy++;
            end
            if (!aborted) begin
                check($sformatf("u%0d_line_bits w=%02h", idx, w), int'(obs), int'(bits));
                check($sformatf("u%0d_line_cycles_wrong", idx), wrongCycles, 0);
                check($sformatf("u%0d_sent_cycle", idx), sentAt, nb * CPB - 1);
                check($sformatf("u%0d_sent_hits", idx), sentHits, 1);
                check($sformatf("u%0d_busy_in_frame", idx), notBusy, 0);
                frames[idx]++;
            end
            inFrame[idx] = 1'b0;
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_fifo_if #(.DATA_BITS(DBITS[g]), .DEPTH(DEP)) bus ();
        assign bus.Din   = din[g][DBITS[g]-1:0];
        assign bus.Wr    = wr[g];
        assign ready[g]  = bus.Ready;
        assign level[g]  = bus.Level;
        assign ovf[g]    = bus.Overflow;

        uart_tx_fifo #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DBITS[g]),
            .PARITY       (PMODE[g]),
            .STOP_BITS    (SBITS[g]),
            .DEPTH        (DEP)
        ) dut (
            .clk     (clk),
            .Reset_n (Reset_n),
            .bus     (bus),
            .Sent    (sent[g]),
            .Busy    (busy[g]),
            .Sout    (sout[g]),
            .State   (stDbg[g])
        );

        initial monitor(g);
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic writeWord(int idx, logic [7:0] w, bit accepted);
        din[idx] = w;
        wr[idx] = 1'b1;
        @(negedge clk);
        wr[idx] = 1'b0;
        if (accepted) pushExp(idx, w);
    endtask

    task automatic waitTo(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic waitIdle(int idx);
        int n = 0;
        while ((pending(idx) > 0 || inFrame[idx]) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check($sformatf("u%0d_drain_timeout pending", idx), pending(idx), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic randomRun(int idx, int bursts);
        int n;
        for (int b = 0; b < bursts; b++) begin
            waitIdle(idx);
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                writeWord(idx, 8'($urandom_range(0, 255)), 1'b1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        waitIdle(idx);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int e, sc, f, highBad;
        logic [7:0] wv [7];
        for (int i = 0; i < NI; i++) begin
            din[i] = '0; inFrame[i] = 1'b0; frames[i] = 0; sentCnt[i] = 0;
        end
        wr = '0;
        Reset_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_sout_u%0d", i), int'(sout[i]), 1);
            check($sformatf("rst_busy_u%0d", i), int'(busy[i]), 0);
            check($sformatf("rst_level_u%0d", i), int'(level[i]), 0);
            check($sformatf("rst_ready_u%0d", i), int'(ready[i]), 1);
            check($sformatf("rst_ovf_u%0d", i), int'(ovf[i]), 0);
            check($sformatf("rst_sent_u%0d", i), int'(sent[i]), 0);
            check($sformatf("rst_state_u%0d", i), int'(stDbg[i]), int'(IDLE));
        end
        Reset_n = 1'b1;
        @(negedge clk);

        // Single write of 0x55: start one cycle after the write edge
        sc = sentCnt[0];
        writeWord(0, 8'h55, 1'b1);
        check("a_level_after_write", int'(level[0]), 1);
        check("a_sout_before_start", int'(sout[0]), 1);
        @(negedge clk);
        check("a_sout_start_latency", int'(sout[0]), 0);
        check("a_busy_in_frame", int'(busy[0]), 1);
        check("a_level_after_pop", int'(level[0]), 0);
        waitIdle(0);
        check("a_busy_after", int'(busy[0]), 0);
        check("a_sent_pulses", sentCnt[0] - sc, 1);

        // Parity modes with 0x03 on three instances at once
        for (int i = 0; i < 3; i++) begin
            din[i] = 8'h03; wr[i] = 1'b1; pushExp(i, 8'h03);
        end
        @(negedge clk);
        wr = '0;
        e = cyc;
        waitTo(e + 38);
        check("b_even_parity_bit", int'(sout[1]), 0);
        check("b_odd_parity_bit", int'(sout[0]), 1);
        check("b_none_stop_bit", int'(sout[2]), 1);
        waitTo(e + 40);
        check("b_none_busy_last_cycle", int'(busy[2]), 1);
        waitTo(e + 41);
        check("b_none_frame_40", int'(busy[2]), 0);
        check("b_odd_still_busy", int'(busy[0]), 1);
        for (int i = 0; i < 3; i++) waitIdle(i);

        // Back-to-back 0xA1, 0xB2, 0xC3
        sc = sentCnt[0];
        writeWord(0, 8'hA1, 1'b1);
        e = cyc;
        check("c_level_w1", int'(level[0]), 1);
        writeWord(0, 8'hB2, 1'b1);
        check("c_level_w2_pop", int'(level[0]), 1);
        writeWord(0, 8'hC3, 1'b1);
        check("c_level_w3", int'(level[0]), 2);
        waitTo(e + 44);
        check("c_level_before_f2", int'(level[0]), 2);
        check("c_stop_f1", int'(sout[0]), 1);
        waitTo(e + 45);
        check("c_level_f2_start", int'(level[0]), 1);
        check("c_no_gap_f2", int'(sout[0]), 0);
        waitTo(e + 89);
        check("c_level_f3_start", int'(level[0]), 0);
        check("c_no_gap_f3", int'(sout[0]), 0);
        waitIdle(0);
        check("c_sent_pulses", sentCnt[0] - sc, 3);

        // Fill to DEPTH while busy, overflow, then write on the pop edge
        for (int i = 0; i < 7; i++) wv[i] = 8'($urandom_range(0, 255));
        writeWord(0, wv[0], 1'b1);
        e = cyc;
        writeWord(0, wv[1], 1'b1);
        writeWord(0, wv[2], 1'b1);
        writeWord(0, wv[3], 1'b1);
        check("d_ready_at_3", int'(ready[0]), 1);
        writeWord(0, wv[4], 1'b1);
        check("d_ready_full", int'(ready[0]), 0);
        check("d_level_full", int'(level[0]), 4);
        writeWord(0, wv[5], 1'b0);
        check("d_overflow_pulse", int'(ovf[0]), 1);
        check("d_level_after_ovf", int'(level[0]), 4);
        @(negedge clk);
        check("d_overflow_one_cycle", int'(ovf[0]), 0);
        waitTo(e + 44);
        writeWord(0, wv[6], 1'b1);
        check("d_pop_edge_level", int'(level[0]), 4);
        check("d_pop_edge_no_ovf", int'(ovf[0]), 0);
        waitIdle(0);

        // Reset during bit 3 of a frame with a second word queued
        writeWord(0, 8'h5A, 1'b1);
        e = cyc;
        writeWord(0, 8'h33, 1'b1);
        waitTo(e + 14);
        check("e_sout_bit3", int'(sout[0]), 0);
        #2;
        Reset_n = 1'b0;
        #1;
        check("e_sout_async", int'(sout[0]), 1);
        check("e_busy_async", int'(busy[0]), 0);
        check("e_level_async", int'(level[0]), 0);
        dropExp(0);
        @(negedge clk);
        @(negedge clk);
        Reset_n = 1'b1;
        f = frames[0];
        highBad = 0;
        repeat (100) begin
            @(negedge clk);
            if (sout[0] !== 1'b1) highBad++;
        end
        check("e_level_after_release", int'(level[0]), 0);
        check("e_line_stays_idle", highBad, 0);
        check("e_no_new_frames", frames[0] - f, 0);

        // 5 data bits, 2 stop bits, 0x1F
        writeWord(3, 8'h1F, 1'b1);
        e = cyc;
        waitTo(e + 28);
        check("f_parity_bit", int'(sout[3]), 0);
        highBad = 0;
        for (int k = 29; k <= 36; k++) begin
            waitTo(e + k);
            if (sout[3] !== 1'b1) highBad++;
        end
        check("f_stop_8_cycles_high", highBad, 0);
        check("f_busy_last_cycle", int'(busy[3]), 1);
        waitTo(e + 37);
        check("f_frame_36", int'(busy[3]), 0);
        waitIdle(3);

        // Randomized bursts on all instances in parallel
        fork
            randomRun(0, 5);
            randomRun(1, 5);
            randomRun(2, 5);
            randomRun(3, 5);
        join

        for (int i = 0; i < NI; i++) waitIdle(i);
        check("end_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
